// File: rtl/vppm_modulador.sv
// VPPM transmitter: frames a parallel word as one start symbol plus DATA_W
// pulse-position symbols, MSB first, with runtime period and pulse width.
module vppm_modulador #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  period_cycles,
   input  logic [CNT_W-1:0]  pulse_width,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              vppm_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA} state_t;

   state_t             stateQ, stateD;
   logic [CNT_W-1:0]   phQ, phD;
   logic [BIT_W-1:0]   bitQ, bitD;
   logic [DATA_W-1:0]  shiftQ, shiftD;
   logic [CNT_W-1:0]   pQ, pD;
   logic [CNT_W-1:0]   wQ, wD;
   logic               symEnd, lastCycle, xfer, nextLevel;

   function automatic logic [CNT_W-1:0] clampPeriod(input logic [CNT_W-1:0] p);
      return (p < CNT_W'(2)) ? CNT_W'(2) : p;
   endfunction

   function automatic logic [CNT_W-1:0] clampWidth(input logic [CNT_W-1:0] w,
                                                   input logic [CNT_W-1:0] pe);
      if (w == '0)
         return CNT_W'(1);
      else if (w >= pe)
         return pe - CNT_W'(1);
      else
         return w;
   endfunction

   // Zero pulses at the start of the symbol, one pulses at its end.
   function automatic logic symbolLevel(input logic b,
                                        input logic [CNT_W-1:0] ph,
                                        input logic [CNT_W-1:0] pe,
                                        input logic [CNT_W-1:0] we);
      return b ? (ph >= pe - we) : (ph < we);
   endfunction

   assign symEnd     = (phQ == pQ - CNT_W'(1));
   assign lastCycle  = (stateQ == DATA) && (bitQ == LAST_BIT) && symEnd;
   assign tx_ready   = (stateQ == IDLE) || lastCycle;
   assign xfer       = tx_valid && tx_ready;
   assign busy       = (stateQ != IDLE);
   assign frame_done = lastCycle;

   always_comb begin
      stateD    = stateQ;
      phD       = phQ;
      bitD      = bitQ;
      shiftD    = shiftQ;
      pD        = pQ;
      wD        = wQ;
      nextLevel = 1'b0;
      if (xfer) begin
         stateD = START;
         phD    = '0;
         bitD   = '0;
         shiftD = tx_data;
         pD     = clampPeriod(period_cycles);
         wD     = clampWidth(pulse_width, clampPeriod(period_cycles));
      end else begin
         case (stateQ)
            START: begin
               if (symEnd) begin
                  stateD = DATA;
                  phD    = '0;
               end else begin
                  phD = phQ + CNT_W'(1);
               end
            end
            DATA: begin
               if (symEnd) begin
                  phD = '0;
                  if (bitQ == LAST_BIT) begin
                     stateD = IDLE;
                  end else begin
                     bitD   = bitQ + BIT_W'(1);
                     shiftD = shiftQ << 1;
                  end
               end else begin
                  phD = phQ + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
      // Line level is computed from the next symbol position so the register
      // presents it aligned with that position.
      case (stateD)
         START:   nextLevel = symbolLevel(1'b0, phD, pD, wD);
         DATA:    nextLevel = symbolLevel(shiftD[DATA_W-1], phD, pD, wD);
         default: nextLevel = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ   <= IDLE;
         phQ      <= '0;
         bitQ     <= '0;
         vppm_out <= 1'b0;
      end else begin
         stateQ   <= stateD;
         phQ      <= phD;
         bitQ     <= bitD;
         vppm_out <= nextLevel;
      end
   end

   always_ff @(posedge clk) begin
      shiftQ <= shiftD;
      pQ     <= pD;
      wQ     <= wD;
   end

endmodule

// File: tb/tb_vppm_modulador.sv
// Directed bench for vppm_modulador: frame shape, back-to-back, clamping,
// latched parameters, async reset abort and busy-time rejection.
module tb_vppm_modulador;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [24:0] period_cycles;
   logic [24:0] pulse_width;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready, vppm_out, busy, frame_done;

   int nChecks = 0;
   int nFails  = 0;

   vppm_modulador #(.DATA_W(8), .CNT_W(25)) dut (
      .clk(clk), .rst_n(rst_n), .period_cycles(period_cycles),
      .pulse_width(pulse_width), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .vppm_out(vppm_out), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Expected line level k cycles after the transfer, for effective P/W.
   function automatic logic expOut(input logic [7:0] d, input int pe, input int we, input int k);
      int sym, ph;
      logic b;
      sym = k / pe;
      ph  = k % pe;
      b   = (sym == 0) ? 1'b0 : d[8 - sym];
      return b ? (ph >= pe - we) : (ph < we);
   endfunction

   task automatic startWord(input logic [7:0] d, input int p, input int w);
      @(negedge clk);
      tx_data       = d;
      period_cycles = 25'(p);
      pulse_width   = 25'(w);
      tx_valid      = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] got;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
      period_cycles = 25'd10; pulse_width = 25'd3;
      repeat (2) @(posedge clk);
      #1 got = {vppm_out, busy, frame_done, tx_ready};
      nChecks++;
      if (got !== 4'b0001) begin
         nFails++; $display("FAIL reset_state got %b required %b", got, 4'b0001);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         got = {vppm_out, busy, frame_done, tx_ready};
         nChecks++;
         if (got !== 4'b0001) begin
            nFails++; $display("FAIL idle_hold k=%0d got %b required %b", k, got, 4'b0001);
         end
      end
   endtask

   task automatic test_frame_a5();
      logic [3:0] got, exp;
      startWord(8'hA5, 10, 3);
      for (int k = 0; k < 95; k++) begin
         @(negedge clk);
         got = {vppm_out, busy, frame_done, tx_ready};
         if (k < 90) exp = {expOut(8'hA5, 10, 3, k), 1'b1, k == 89, k == 89};
         else        exp = 4'b0001;
         nChecks++;
         if (got !== exp) begin
            nFails++; $display("FAIL frame_a5 k=%0d got %b required %b", k, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] got, exp;
      logic [7:0] d;
      int busyCnt, lk;
      busyCnt = 0;
      @(negedge clk);
      tx_data = 8'hFF; period_cycles = 25'd10; pulse_width = 25'd3; tx_valid = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 185; k++) begin
         @(negedge clk);
         got = {vppm_out, busy, frame_done, tx_ready};
         if (busy) busyCnt++;
         lk = k % 90;
         d  = (k < 90) ? 8'hFF : 8'h00;
         if (k < 180) exp = {expOut(d, 10, 3, lk), 1'b1, lk == 89, lk == 89};
         else         exp = 4'b0001;
         nChecks++;
         if (got !== exp) begin
            nFails++; $display("FAIL back_to_back k=%0d got %b required %b", k, got, exp);
         end
         if (k == 0)  tx_data  = 8'h00;
         if (k == 90) tx_valid = 1'b0;
      end
      nChecks++;
      if (busyCnt !== 180) begin
         nFails++; $display("FAIL b2b_busy_cycles got %0d required %0d", busyCnt, 180);
      end
   endtask

   task automatic test_clamp(input int p, input int w, input int pe, input int we);
      logic [3:0] got, exp;
      int len;
      len = 9 * pe;
      startWord(8'hA5, p, w);
      for (int k = 0; k < len + 2; k++) begin
         @(negedge clk);
         got = {vppm_out, busy, frame_done, tx_ready};
         if (k < len) exp = {expOut(8'hA5, pe, we, k), 1'b1, k == len - 1, k == len - 1};
         else         exp = 4'b0001;
         nChecks++;
         if (got !== exp) begin
            nFails++;
            $display("FAIL clamp_p%0d_w%0d k=%0d got %b required %b", p, w, k, got, exp);
         end
      end
   endtask

   task automatic test_param_latch();
      logic [3:0] got, exp;
      startWord(8'h5A, 10, 3);
      for (int k = 0; k < 90; k++) begin
         @(negedge clk);
         got = {vppm_out, busy, frame_done, tx_ready};
         exp = {expOut(8'h5A, 10, 3, k), 1'b1, k == 89, k == 89};
         nChecks++;
         if (got !== exp) begin
            nFails++; $display("FAIL latch_old k=%0d got %b required %b", k, got, exp);
         end
         if (k == 15) begin
            period_cycles = 25'd6; pulse_width = 25'd2; tx_data = 8'h00;
         end
      end
      startWord(8'h96, 6, 2);
      for (int k = 0; k < 56; k++) begin
         @(negedge clk);
         got = {vppm_out, busy, frame_done, tx_ready};
         if (k < 54) exp = {expOut(8'h96, 6, 2, k), 1'b1, k == 53, k == 53};
         else        exp = 4'b0001;
         nChecks++;
         if (got !== exp) begin
            nFails++; $display("FAIL latch_new k=%0d got %b required %b", k, got, exp);
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [3:0] got, exp;
      startWord(8'hFF, 10, 6);
      for (int k = 0; k <= 44; k++) begin
         @(negedge clk);
         got = {vppm_out, busy, frame_done, tx_ready};
         exp = {expOut(8'hFF, 10, 6, k), 1'b1, 1'b0, 1'b0};
         nChecks++;
         if (got !== exp) begin
            nFails++; $display("FAIL abort_pre k=%0d got %b required %b", k, got, exp);
         end
      end
      #2 rst_n = 1'b0;
      #1 got = {vppm_out, busy, frame_done, tx_ready};
      nChecks++;
      if (got !== 4'b0001) begin
         nFails++; $display("FAIL abort_async got %b required %b", got, 4'b0001);
      end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      startWord(8'hA5, 10, 3);
      for (int k = 0; k < 92; k++) begin
         @(negedge clk);
         got = {vppm_out, busy, frame_done, tx_ready};
         if (k < 90) exp = {expOut(8'hA5, 10, 3, k), 1'b1, k == 89, k == 89};
         else        exp = 4'b0001;
         nChecks++;
         if (got !== exp) begin
            nFails++; $display("FAIL abort_fresh k=%0d got %b required %b", k, got, exp);
         end
      end
   endtask

   task automatic test_busy_reject();
      logic [3:0] got, exp;
      startWord(8'h3C, 4, 1);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         got = {vppm_out, busy, frame_done, tx_ready};
         if (k < 36) exp = {expOut(8'h3C, 4, 1, k), 1'b1, k == 35, k == 35};
         else        exp = 4'b0001;
         nChecks++;
         if (got !== exp) begin
            nFails++; $display("FAIL busy_reject k=%0d got %b required %b", k, got, exp);
         end
         if (k == 5) begin
            tx_data = 8'hC3; tx_valid = 1'b1;
         end
         if (k == 30) tx_valid = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_back_to_back();
      test_clamp(10, 0, 10, 1);
      test_clamp(10, 12, 10, 9);
      test_clamp(1, 1, 2, 1);
      test_param_latch();
      test_reset_abort();
      test_busy_reject();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
